// File: rtl/regs_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine: FSM states, frame
// constants and the per-register record layout.
package regs_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_REG     = 5;
    localparam int         RECORD_W          = BYTES_PER_REG * 8;

    // One register record: zero-extended index byte followed by the data word, MSB first.
    function automatic logic [RECORD_W-1:0] pack_record(input logic [4:0]  idx,
                                                        input logic [31:0] data);
        return {3'b000, idx, data};
    endfunction

endpackage

// File: rtl/regs_dump_reader.sv
// Freezes the CPU, walks a window of the register file through one read port
// and streams a sync byte plus 5 bytes per register over a valid/ready link.
module regs_dump_reader
    import regs_dump_reader_pkg::*;
#(
    parameter int         FIRST_REG = 0,
    parameter int         LAST_REG  = 31,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cpu_hold,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REG - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [4:0]            r_cur;
    logic [4:0]            w_cur_next;
    logic [4:0]            r_rd_addr;
    logic [2:0]            r_byte_cnt;
    logic [RECORD_W-1:0]   r_shift;
    logic                  w_hs;
    logic                  w_last_byte;

    // Outputs are decoded from state only, so out_valid never depends on out_ready.
    assign w_hs        = out_valid && out_ready;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_HDR;
                    w_cur_next   = FIRST_IDX;
                end
            end
            ST_HDR: begin
                if (w_hs) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs && w_last_byte) begin
                    if (r_cur == LAST_IDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ADDR;
                        w_cur_next   = r_cur + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_hold  = (r_state != ST_IDLE);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        out_valid = (r_state == ST_HDR) || (r_state == ST_SEND);
        out_data  = 8'h00;
        if (r_state == ST_HDR)  out_data = SYNC_BYTE;
        if (r_state == ST_SEND) out_data = r_shift[RECORD_W-1 -: 8];
    end

    assign rd_addr = r_rd_addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cur      <= 5'd0;
            r_rd_addr  <= 5'd0;
            r_byte_cnt <= 3'd0;
            r_shift    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
            // Address is loaded on entry to ADDR so it is stable for the whole capture cycle.
            if (w_state_next == ST_ADDR) r_rd_addr <= w_cur_next;

            if (r_state == ST_ADDR) begin
                r_shift    <= pack_record(r_cur, rd_data);
                r_byte_cnt <= 3'd0;
            end else if (r_state == ST_SEND && w_hs) begin
                r_shift    <= {r_shift[RECORD_W-9:0], 8'h00};
                r_byte_cnt <= r_byte_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_regs_dump_reader.sv
// Self-checking bench: a behavioural register file feeds two engines (full
// window and an 8..9 window); streams are compared against a byte-list model.
module tb_regs_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, ready_a = 1'b0;
    logic        start_b = 1'b0, ready_b = 1'b0;
    logic        hold_a, hold_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [4:0]  addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic [31:0] rdat_a, rdat_b;
    logic [31:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rdat_a = (addr_a == 5'd0) ? 32'h0 : mem[addr_a];
    assign rdat_b = (addr_b == 5'd0) ? 32'h0 : mem[addr_b];

    regs_dump_reader u_full (
        .clk(clk), .rst(rst), .start(start_a), .cpu_hold(hold_a), .rd_addr(addr_a),
        .rd_data(rdat_a), .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
        .busy(busy_a), .done(done_a)
    );

    regs_dump_reader #(.FIRST_REG(8), .LAST_REG(9)) u_win (
        .clk(clk), .rst(rst), .start(start_b), .cpu_hold(hold_b), .rd_addr(addr_b),
        .rd_data(rdat_b), .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream straight from the frame rules: sync byte, then index + data MSB first.
    task automatic build_expected(input int first, input int last, output logic [7:0] q[$]);
        logic [31:0] v;
        q = {};
        q.push_back(8'hA5);
        for (int i = first; i <= last; i++) begin
            v = (i == 0) ? 32'h0 : mem[i];
            q.push_back(8'(i));
            q.push_back(v[31:24]);
            q.push_back(v[23:16]);
            q.push_back(v[15:8]);
            q.push_back(v[7:0]);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic run_dump(input bit sel, input int ready_mode, input int extra_start,
                            input bit try_writes, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int first, last, nregs, cyc, done_cyc, ndone, nbusy;
        logic m_valid, m_busy, m_done, m_hold, rdy, prev_stall;
        logic [7:0] m_data, prev_data;
        first = sel ? 8 : 0;
        last  = sel ? 9 : 31;
        nregs = last - first + 1;
        build_expected(first, last, exp_q);
        got_q = {};
        cyc = 0; done_cyc = 0; ndone = 0; nbusy = 0; prev_stall = 1'b0; prev_data = 8'h0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == extra_start) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            m_valid = sel ? valid_b : valid_a;
            m_data  = sel ? data_b  : data_a;
            m_busy  = sel ? busy_b  : busy_a;
            m_done  = sel ? done_b  : done_a;
            m_hold  = sel ? hold_b  : hold_a;
            if (prev_stall) check({tag, "_stall_stable"}, {m_valid, m_data}, {1'b1, prev_data});
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                check({tag, "_hold_after_done"}, {m_hold, m_busy, m_done}, 3'b000);
                break;
            end
            if (m_done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (m_busy && !m_done) nbusy++;
            // The controller only lets register-file writes through while cpu_hold is low.
            if (try_writes && !hold_a && !hold_b && cyc > 1) mem[$urandom_range(1, 31)] = $urandom;
            if (try_writes && (hold_a || hold_b)) begin
                check({tag, "_hold_high"}, m_hold, 1'b1);
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (sel) ready_b = rdy; else ready_a = rdy;
            if (m_valid && rdy) got_q.push_back(m_data);
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
        end
        if (cyc >= 4000) check({tag, "_timeout"}, 1'b0, 1'b1);
        ready_a = 1'b0;
        ready_b = 1'b0;
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_done_pulses"}, ndone, 1);
        if (ready_mode == 0) begin
            check({tag, "_done_latency"}, done_cyc, 1 + nregs * 6 + 1);
            check({tag, "_busy_cycles"}, nbusy, 1 + nregs * 6);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {hold_a, busy_a, done_a, valid_a, data_a, addr_a},
              {4'b0000, 8'h00, 5'd0});

        // Abort from HDR with async reset.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("hdr_entered", {valid_a, hold_a, data_a}, {2'b11, 8'hA5});
        #2 rst = 1'b1;
        #1 check("async_reset", {hold_a, busy_a, done_a, valid_a, data_a, addr_a},
                 {4'b0000, 8'h00, 5'd0});
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", {done_a, busy_a}, 2'b00);
        end

        run_dump(1'b0, 0, 0, 1'b0, "full");
        run_dump(1'b0, 1, 0, 1'b0, "backpressure");

        mem[8] = 32'hDEAD_BEEF;
        mem[9] = 32'h0;
        run_dump(1'b1, 0, 0, 1'b0, "window");

        run_dump(1'b0, 0, 20, 1'b0, "start_busy");

        for (int i = 1; i < 32; i++) mem[i] = $urandom;
        run_dump(1'b0, 2, 0, 1'b1, "hold_writes");

        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i < 32; i++) mem[i] = $urandom;
            run_dump(1'(r % 2), 2, 0, 1'b0, $sformatf("random%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regs_dump_reader.md
Name: regs_dump_reader

Overview:
- Debug read-out engine for the multi-cycle CPU's 32x32 register file.
- Connects to one register-file read port as the initiator of read requests.
- On a start pulse: freezes the CPU, walks registers FIRST_REG..LAST_REG, and streams each as framed bytes over a valid/ready byte interface (UART TX or display buffer).
- Sits beside the register file; its address output muxes into the read-A address while cpu_hold is high.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31); FIRST_REG > LAST_REG is illegal.
- SYNC_BYTE, 8'hA5, frame header byte emitted once per dump.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle dump request; sampled in IDLE only.
- cpu_hold  output  1  high while busy; CPU controller must deassert register-file we and stall.
- rd_addr  output  5  registered read address to the register file.
- rd_data  input  32  combinational read data from the register file (index 0 reads 0).
- out_data  output  8  stream byte.
- out_valid  output  1  stream byte valid.
- out_ready  input  1  downstream accepts byte when out_valid&out_ready at posedge.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse at end of dump.

Behaviour:
- Reset (async): state=IDLE; cpu_hold=0, busy=0, done=0, out_valid=0, out_data=0, rd_addr=0; counters cleared. Reset mid-dump aborts immediately, with no partial completion and no done pulse.
- States:
  - IDLE: start=1 -> HDR; load cur=FIRST_REG.
  - HDR: out_valid=1, out_data=SYNC_BYTE, cpu_hold=1; handshake -> ADDR.
  - ADDR: rd_addr=cur (registered, stable whole cycle); out_valid=0. At the ending posedge, latch {cur[7:0] zero-extended, rd_data} into a 40-bit shift register; -> SEND with byte_cnt=0.
  - SEND: out_valid=1; out_data=shift[39:32]. On handshake, shift left 8 and byte_cnt+1. After 5th handshake: if cur==LAST_REG -> DONE, else cur+1 -> ADDR.
  - DONE: done=1 for one cycle; cpu_hold, busy drop to 0 next cycle; -> IDLE.
- Byte order per register: index, data[31:24], data[23:16], data[15:8], data[7:0].
- Stream rules: out_data/out_valid held stable while out_valid=1 and out_ready=0; valid never withdrawn before handshake; no dependence of out_valid on out_ready.
- cpu_hold rises in the same cycle the state enters HDR, so the register file sees no write during ADDR cycles. The register file writes on negedge; one full HDR handshake precedes the first capture, so an in-flight negedge write completes before capture.
- start while busy: ignored, not queued.
- cur counter is 5 bits; no wrap since cur stops at LAST_REG ≤ 31.
- Latency with out_ready held 1: per register 6 cycles (1 ADDR + 5 SEND). Full default dump is 1 + 32*6 = 193 busy cycles with state≠IDLE/DONE, then 1 DONE cycle; 161 bytes total.
- Backpressure stalls only SEND/HDR; ADDR capture is never stalled.

Decomposition:
- Shared package/header: state encodings (IDLE, HDR, ADDR, SEND, DONE), SYNC_BYTE default, BYTES_PER_REG=5.
- No sub-module; a single FSM + shift register. An optional UART TX consumer is a separate existing-style block, not part of this one.

Test Plan:
- Reset-then-idle: rst=1 mid-HDR -> all outputs 0 in the same cycle (async); no done; later start runs a full fresh dump.
- Full dump, out_ready=1: regfile preloaded reg[i]=32'h1000_0000+i, reg0 written 32'hFFFF_FFFF (reads 0) -> bytes A5, 00,00,00,00,00, 01,10,00,00,01, ... 1F,10,00,00,1F; 161 bytes; done 194 cycles after start.
- Backpressure: out_ready toggles 1,0,0,1 pattern -> out_data stable across stalled cycles; byte sequence identical to the no-stall run.
- Parameter window FIRST_REG=8, LAST_REG=9, reg8=32'hDEADBEEF, reg9=32'h0 -> A5, 08,DE,AD,BE,EF, 09,00,00,00,00; then done.
- start while busy: second start pulse at cycle 20 -> ignored; exactly one done and 161 bytes.
- Hold: CPU attempts we=1 while cpu_hold=1 (controller gated) -> captured values equal pre-dump contents; cpu_hold=0 the cycle after done.
